// File: rtl/rfb_write_arbiter_if.sv
// Write-port bundle between the frame-buffer arbiter, its point renderers and the frame buffer.
// master = arbiter side, slave = renderer/frame-buffer side.
interface rfb_write_arbiter_if #(
  parameter int NUM_REQ        = 2,
  parameter int ROTATIONAL_RES = 1024,
  parameter int DISPLAY_RADIUS = 32,
  parameter int DISPLAY_HEIGHT = 64
);
  localparam int TW = $clog2(ROTATIONAL_RES);
  localparam int RW = $clog2(DISPLAY_RADIUS);
  localparam int ZW = $clog2(DISPLAY_HEIGHT);

  logic                  frame_start;
  logic                  buffer_busy;
  logic                  flush_out;
  logic                  new_data_out;
  logic [TW-1:0]         theta_out;
  logic [RW-1:0]         radius_out;
  logic [ZW-1:0]         z_out;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*TW-1:0] req_theta;
  logic [NUM_REQ*RW-1:0] req_radius;
  logic [NUM_REQ*ZW-1:0] req_z;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_done;
  logic                  frame_go;
  logic                  frame_active;
  logic                  frame_done;

  modport master (
    input  frame_start, buffer_busy, req_valid, req_theta, req_radius, req_z, req_done,
    output flush_out, new_data_out, theta_out, radius_out, z_out, req_ready,
           frame_go, frame_active, frame_done
  );

  modport slave (
    output frame_start, buffer_busy, req_valid, req_theta, req_radius, req_z, req_done,
    input  flush_out, new_data_out, theta_out, radius_out, z_out, req_ready,
           frame_go, frame_active, frame_done
  );
endinterface

// File: rtl/rfb_write_arbiter.sv
// Per-frame flush/release sequencer plus round-robin arbiter onto the frame buffer's single write port.
// Accept-to-strobe latency 1 cycle, one point per cycle; no grants while buffer_busy is high.
module rfb_write_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ROTATIONAL_RES = 1024,
  parameter int DISPLAY_RADIUS = 32,
  parameter int DISPLAY_HEIGHT = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  rfb_write_arbiter_if.master bus
);
  localparam int TW = $clog2(ROTATIONAL_RES);
  localparam int RW = $clog2(DISPLAY_RADIUS);
  localparam int ZW = $clog2(DISPLAY_HEIGHT);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_FLUSH, S_FLUSH_WAIT, S_DRAW, S_DONE} state_t;

  typedef struct packed {
    logic [TW-1:0] theta;
    logic [RW-1:0] radius;
    logic [ZW-1:0] z;
  } point_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_flush;
  logic               r_go;
  logic               r_active;
  logic               r_fdone;
  logic               r_new_data;
  logic               w_flush_nxt;
  logic               w_go_nxt;
  logic               w_active_nxt;
  logic               w_fdone_nxt;
  logic [NUM_REQ-1:0] r_done_mask;
  logic [NUM_REQ-1:0] w_done_mask_nxt;
  logic [NUM_REQ-1:0] w_eligible;
  logic [NUM_REQ-1:0] w_ready;
  logic [PW-1:0]      r_rr_ptr;
  logic [PW-1:0]      w_rr_nxt;
  logic [PW-1:0]      w_grant_idx;
  logic [PW-1:0]      w_idx;
  logic [SW-1:0]      w_idx_sum;
  logic               w_grant_vld;
  logic               w_search_en;
  point_t             r_point;
  point_t             w_sel_point;

  assign w_search_en = (r_state == S_DRAW) && !bus.buffer_busy;
  assign w_eligible  = bus.req_valid & ~r_done_mask;

  // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ (not necessarily a power of two).
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_idx_sum   = '0;
    w_idx       = '0;
    if (w_search_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx_sum = {1'b0, r_rr_ptr} + SW'(k);
        if (w_idx_sum >= SW'(NUM_REQ)) begin
          w_idx_sum = w_idx_sum - SW'(NUM_REQ);
        end
        w_idx = w_idx_sum[PW-1:0];
        if (!w_grant_vld && w_eligible[w_idx]) begin
          w_grant_vld = 1'b1;
          w_grant_idx = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_sel_point        = '0;
    w_sel_point.theta  = bus.req_theta[int'(w_grant_idx)*TW +: TW];
    w_sel_point.radius = bus.req_radius[int'(w_grant_idx)*RW +: RW];
    w_sel_point.z      = bus.req_z[int'(w_grant_idx)*ZW +: ZW];
  end

  assign w_ready  = w_grant_vld ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign w_rr_nxt = (w_grant_idx == PW'(NUM_REQ - 1)) ? '0 : w_grant_idx + PW'(1);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_nxt     = 1'b0;
    w_go_nxt        = 1'b0;
    w_fdone_nxt     = 1'b0;
    w_active_nxt    = r_active;
    w_done_mask_nxt = r_done_mask;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_start && !bus.buffer_busy) begin
          w_flush_nxt  = 1'b1;
          w_active_nxt = 1'b1;
          w_state_nxt  = S_FLUSH;
        end
      end
      // Guard cycle: the buffer may only raise busy one cycle after seeing the flush.
      S_FLUSH: w_state_nxt = S_FLUSH_WAIT;
      S_FLUSH_WAIT: begin
        if (!bus.buffer_busy) begin
          w_go_nxt        = 1'b1;
          w_done_mask_nxt = '0;
          w_state_nxt     = S_DRAW;
        end
      end
      S_DRAW: begin
        w_done_mask_nxt = r_done_mask | bus.req_done;
        // Mask is registered, so the strobe of any point accepted alongside the last done is out now.
        if (&r_done_mask) begin
          w_fdone_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_active_nxt = 1'b0;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_flush     <= 1'b0;
      r_go        <= 1'b0;
      r_active    <= 1'b0;
      r_fdone     <= 1'b0;
      r_done_mask <= '0;
      r_new_data  <= 1'b0;
      r_rr_ptr    <= '0;
      r_point     <= '0;
    end else begin
      r_flush     <= w_flush_nxt;
      r_go        <= w_go_nxt;
      r_active    <= w_active_nxt;
      r_fdone     <= w_fdone_nxt;
      r_done_mask <= w_done_mask_nxt;
      r_new_data  <= w_grant_vld;
      if (w_grant_vld) begin
        r_point  <= w_sel_point;
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.flush_out    = r_flush;
  assign bus.frame_go     = r_go;
  assign bus.frame_active = r_active;
  assign bus.frame_done   = r_fdone;
  assign bus.new_data_out = r_new_data;
  assign bus.theta_out    = r_point.theta;
  assign bus.radius_out   = r_point.radius;
  assign bus.z_out        = r_point.z;
endmodule

// File: tb/tb_rfb_write_arbiter.sv
// Bench for rfb_write_arbiter: directed vector table for one full frame plus randomized frames
// checked against a point-level round-robin model.
module tb_rfb_write_arbiter;
  localparam int N  = 2;
  localparam int TW = 10;
  localparam int RW = 5;
  localparam int ZW = 6;
  localparam int NV = 26;
  localparam int FRAME_BUDGET = 600;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rfb_write_arbiter_if #(.NUM_REQ(N)) bus();
  rfb_write_arbiter #(.NUM_REQ(N)) dut (.clk_in(clk), .rst_in(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  logic [N-1:0]  in_v;
  logic [N-1:0]  in_dn;
  logic          in_bz;
  logic          in_fs;
  logic [TW-1:0] p_th [N];
  logic [RW-1:0] p_r  [N];
  logic [ZW-1:0] p_z  [N];

  // Reference model: what the frame buffer should see, tracked per point.
  logic          m_draw;
  logic          m_active;
  logic          m_fdone;
  logic          m_strobe;
  logic [N-1:0]  m_done;
  int            m_next;
  logic [TW-1:0] m_th;
  logic [RW-1:0] m_r;
  logic [ZW-1:0] m_z;

  typedef struct {
    logic [N-1:0]  v;
    logic [N-1:0]  dn;
    logic          bz;
    logic          fs;
    logic [TW-1:0] th0;
    logic [TW-1:0] th1;
    logic [N-1:0]  rdy;
    logic          nd;
    logic [TW-1:0] th;
    logic          fd;
    logic          act;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(int v, int dn, int bz, int fs, int th0, int th1,
                              int rdy, int nd, int th, int fd, int act);
    vec_t r;
    r.v = N'(v);     r.dn = N'(dn);   r.bz = 1'(bz);    r.fs = 1'(fs);
    r.th0 = TW'(th0); r.th1 = TW'(th1);
    r.rdy = N'(rdy); r.nd = 1'(nd);   r.th = TW'(th);   r.fd = 1'(fd); r.act = 1'(act);
    return r;
  endfunction

  function automatic logic [RW-1:0] rad_of(logic [TW-1:0] t);
    return t[RW-1:0];
  endfunction

  function automatic logic [ZW-1:0] z_of(logic [TW-1:0] t);
    return t[ZW-1:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_point(int i, logic [TW-1:0] t);
    p_th[i] = t;
    p_r[i]  = rad_of(t);
    p_z[i]  = z_of(t);
  endtask

  task automatic drive();
    bus.frame_start = in_fs;
    bus.buffer_busy = in_bz;
    bus.req_valid   = in_v;
    bus.req_done    = in_dn;
    for (int i = 0; i < N; i++) begin
      bus.req_theta[i*TW +: TW]  = p_th[i];
      bus.req_radius[i*RW +: RW] = p_r[i];
      bus.req_z[i*ZW +: ZW]      = p_z[i];
    end
  endtask

  task automatic clear_inputs();
    in_v = '0; in_dn = '0; in_bz = 1'b0; in_fs = 1'b0;
    for (int i = 0; i < N; i++) set_point(i, '0);
  endtask

  task automatic model_reset();
    m_draw = 1'b0; m_active = 1'b0; m_fdone = 1'b0; m_strobe = 1'b0;
    m_done = '0; m_next = 0; m_th = '0; m_r = '0; m_z = '0;
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_flush"},  32'(bus.flush_out), 0);
    chk({tag, "_strobe"}, 32'(bus.new_data_out), 0);
    chk({tag, "_theta"},  32'(bus.theta_out), 0);
    chk({tag, "_radius"}, 32'(bus.radius_out), 0);
    chk({tag, "_z"},      32'(bus.z_out), 0);
    chk({tag, "_ready"},  32'(bus.req_ready), 0);
    chk({tag, "_go"},     32'(bus.frame_go), 0);
    chk({tag, "_active"}, 32'(bus.frame_active), 0);
    chk({tag, "_done"},   32'(bus.frame_done), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    drive();
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Issues frame_start from IDLE, holds busy for nbusy cycles after the flush, expects frame_go.
  task automatic start_frame(int nbusy);
    @(negedge clk);
    clear_inputs();
    in_fs = 1'b1;
    drive();
    #1;
    chk("idle_active", 32'(bus.frame_active), 0);
    chk("idle_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    in_fs = 1'b0;
    drive();
    #1;
    chk("flush_pulse", 32'(bus.flush_out), 1);
    chk("active_on_flush", 32'(bus.frame_active), 1);
    chk("go_early", 32'(bus.frame_go), 0);
    for (int i = 0; i < nbusy; i++) begin
      @(negedge clk);
      in_bz = 1'b1;
      drive();
      #1;
      chk("flush_once", 32'(bus.flush_out), 0);
      chk("go_while_busy", 32'(bus.frame_go), 0);
    end
    @(negedge clk);
    in_bz = 1'b0;
    drive();
    #1;
    chk("go_at_busy_fall", 32'(bus.frame_go), 0);
    @(negedge clk);
    drive();
    #1;
    chk("go_pulse", 32'(bus.frame_go), 1);
    chk("go_no_grant", 32'(bus.req_ready), 0);
    m_draw = 1'b1; m_done = '0; m_strobe = 1'b0; m_fdone = 1'b0; m_active = 1'b1;
  endtask

  // One cycle against the model: inputs in in_*/p_* are applied at the negedge.
  task automatic dstep();
    logic [N-1:0] exp_rdy;
    logic         nxt_fdone;
    int           g;
    int           idx;
    @(negedge clk);
    drive();
    #1;
    exp_rdy = '0;
    g = -1;
    if (m_draw && !in_bz) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_next + k) % N;
        if (g < 0 && in_v[idx] && !m_done[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("m_ready",  32'(bus.req_ready), 32'(exp_rdy));
    chk("m_strobe", 32'(bus.new_data_out), 32'(m_strobe));
    chk("m_theta",  32'(bus.theta_out), 32'(m_th));
    chk("m_radius", 32'(bus.radius_out), 32'(m_r));
    chk("m_z",      32'(bus.z_out), 32'(m_z));
    chk("m_fdone",  32'(bus.frame_done), 32'(m_fdone));
    chk("m_active", 32'(bus.frame_active), 32'(m_active));
    chk("m_go",     32'(bus.frame_go), 0);
    chk("m_flush",  32'(bus.flush_out), 0);
    nxt_fdone = m_draw && (&m_done);
    m_active  = m_active && !m_fdone;
    if (m_draw && (&m_done)) m_draw = 1'b0;
    else if (m_draw) m_done = m_done | in_dn;
    m_fdone  = nxt_fdone;
    m_strobe = (g >= 0);
    if (g >= 0) begin
      m_th   = p_th[g];
      m_r    = p_r[g];
      m_z    = p_z[g];
      m_next = (g + 1) % N;
    end
  endtask

  task automatic rand_inputs(int cyc, bit allow_done);
    in_bz = ($urandom_range(0, 4) == 0);
    in_fs = ($urandom_range(0, 9) == 0);
    in_v  = N'($urandom);
    for (int i = 0; i < N; i++) begin
      in_dn[i] = allow_done && ((cyc > 150) || ($urandom_range(0, 40) == 0));
      p_th[i]  = TW'($urandom);
      p_r[i]   = RW'($urandom);
      p_z[i]   = ZW'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tbl[0]  = mk(3, 0, 0, 0,   10, 20, 1, 0,    0, 0, 1);
    tbl[1]  = mk(3, 0, 0, 0,   11, 21, 2, 1,   10, 0, 1);
    tbl[2]  = mk(3, 0, 0, 0,   12, 22, 1, 1,   21, 0, 1);
    tbl[3]  = mk(3, 0, 0, 1,   13, 23, 2, 1,   12, 0, 1);
    tbl[4]  = mk(1, 0, 0, 0,   14, 24, 1, 1,   23, 0, 1);
    tbl[5]  = mk(1, 0, 0, 0,   15, 25, 1, 1,   14, 0, 1);
    tbl[6]  = mk(1, 0, 1, 0,   16, 26, 0, 1,   15, 0, 1);
    tbl[7]  = mk(1, 0, 1, 0,   16, 26, 0, 0,   15, 0, 1);
    tbl[8]  = mk(1, 0, 1, 0,   16, 26, 0, 0,   15, 0, 1);
    tbl[9]  = mk(1, 0, 0, 0,   16, 26, 1, 0,   15, 0, 1);
    tbl[10] = mk(1, 1, 0, 0, 1023, 27, 1, 1,   16, 0, 1);
    tbl[11] = mk(3, 0, 0, 0,    5, 30, 2, 1, 1023, 0, 1);
    tbl[12] = mk(1, 0, 0, 0,    6, 31, 0, 1,   30, 0, 1);
    tbl[13] = mk(0, 0, 0, 0,    6, 31, 0, 0,   30, 0, 1);
    tbl[14] = mk(2, 0, 0, 0,    6, 40, 2, 0,   30, 0, 1);
    tbl[15] = mk(2, 0, 0, 0,    6, 41, 2, 1,   40, 0, 1);
    tbl[16] = mk(2, 0, 0, 0,    6, 42, 2, 1,   41, 0, 1);
    tbl[17] = mk(2, 0, 0, 0,    6, 43, 2, 1,   42, 0, 1);
    tbl[18] = mk(2, 0, 0, 0,    6, 44, 2, 1,   43, 0, 1);
    tbl[19] = mk(2, 0, 0, 0,    6, 45, 2, 1,   44, 0, 1);
    tbl[20] = mk(2, 2, 0, 0,    6, 46, 2, 1,   45, 0, 1);
    tbl[21] = mk(2, 0, 0, 0,    6, 47, 0, 1,   46, 0, 1);
    tbl[22] = mk(0, 0, 0, 0,    6, 47, 0, 0,   46, 1, 1);
    tbl[23] = mk(0, 0, 0, 0,    6, 47, 0, 0,   46, 0, 0);
    tbl[24] = mk(0, 0, 1, 1,    6, 47, 0, 0,   46, 0, 0);
    tbl[25] = mk(0, 0, 0, 0,    6, 47, 0, 0,   46, 0, 0);

    clear_inputs();
    drive();
    model_reset();

    do_reset();
    start_frame(5);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_v = tbl[i].v; in_dn = tbl[i].dn; in_bz = tbl[i].bz; in_fs = tbl[i].fs;
      set_point(0, tbl[i].th0);
      set_point(1, tbl[i].th1);
      drive();
      #1;
      chk("vec_ready",  32'(bus.req_ready), 32'(tbl[i].rdy));
      chk("vec_strobe", 32'(bus.new_data_out), 32'(tbl[i].nd));
      chk("vec_theta",  32'(bus.theta_out), 32'(tbl[i].th));
      chk("vec_radius", 32'(bus.radius_out), 32'(rad_of(tbl[i].th)));
      chk("vec_z",      32'(bus.z_out), 32'(z_of(tbl[i].th)));
      chk("vec_fdone",  32'(bus.frame_done), 32'(tbl[i].fd));
      chk("vec_active", 32'(bus.frame_active), 32'(tbl[i].act));
      chk("vec_flush",  32'(bus.flush_out), 0);
      chk("vec_go",     32'(bus.frame_go), 0);
    end

    do_reset();
    start_frame(1);
    for (int c = 0; c < 15; c++) begin
      rand_inputs(c, 1'b0);
      dstep();
    end
    in_v = '1; in_bz = 1'b0; in_fs = 1'b0; in_dn = '0;
    dstep();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    drive();
    model_reset();

    for (int f = 0; f < 4; f++) begin
      start_frame(int'($urandom_range(0, 6)));
      cnt = 0;
      while ((m_draw || m_fdone || m_active) && cnt < FRAME_BUDGET) begin
        rand_inputs(cnt, 1'b1);
        dstep();
        cnt++;
      end
      chk("frame_budget", 32'(cnt >= FRAME_BUDGET), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rfb_write_arbiter.md
Name: rfb_write_arbiter

Overview:
- Owns the single write port of the rotational frame buffer and shares it between NUM_REQ point renderers (bouncing ball, static shapes, text, ...).
- Per frame: issues one flush, waits for the buffer to go idle, releases all renderers, then round-robin arbitrates their cylindrical point streams into single-cycle new_data writes.
- Signals frame completion once every renderer reports done.

Parameters:
- NUM_REQ, 2, number of renderer ports (2..8)
- ROTATIONAL_RES, 1024, theta steps; theta width TW = clog2(ROTATIONAL_RES)
- DISPLAY_RADIUS, 32, radius range; radius width RW = clog2(DISPLAY_RADIUS)
- DISPLAY_HEIGHT, 64, z range; z width ZW = clog2(DISPLAY_HEIGHT)

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- frame_start  in  1  single-cycle request to render a new frame
- buffer_busy  in  1  frame buffer busy (flushing or committing)
- flush_out  out  1  one-cycle flush pulse to frame buffer
- new_data_out  out  1  one-cycle write strobe to frame buffer
- theta_out  out  TW  write theta, valid with new_data_out
- radius_out  out  RW  write radius, valid with new_data_out
- z_out  out  ZW  write z, valid with new_data_out
- req_valid  in  NUM_REQ  per-renderer point valid
- req_theta  in  NUM_REQ*TW  packed thetas, renderer i at [i*TW +: TW]
- req_radius  in  NUM_REQ*RW  packed radii
- req_z  in  NUM_REQ*ZW  packed z
- req_ready  out  NUM_REQ  per-renderer grant (one-hot or zero)
- req_done  in  NUM_REQ  renderer finished this frame (pulse or level)
- frame_go  out  1  one-cycle pulse: renderers may start
- frame_active  out  1  high from flush pulse until frame_done
- frame_done  out  1  one-cycle pulse: frame fully written

Behaviour:
- Reset (rst_in low, async): state IDLE; all outputs 0; rr_ptr 0; done_mask 0.
- States: IDLE, FLUSH, FLUSH_WAIT, DRAW, DONE.
- IDLE:
  - frame_start && !buffer_busy: flush_out=1 for one cycle -> FLUSH.
  - frame_start while buffer_busy: dropped, not queued.
- FLUSH: one guard cycle, because busy may rise one cycle after flush -> FLUSH_WAIT.
- FLUSH_WAIT:
  - Hold until buffer_busy==0.
  - Then pulse frame_go, clear done_mask -> DRAW.
- DRAW:
  - Grant computed combinationally each cycle. Eligible renderer i: req_valid[i] && !done_mask[i]; search starts at rr_ptr, wraps modulo NUM_REQ.
  - At most one req_ready bit set. All req_ready=0 when buffer_busy=1 or state!=DRAW.
  - Transfer: req_valid[g] && req_ready[g]. Next cycle: new_data_out=1 with theta/radius/z registered from renderer g; rr_ptr <= (g+1) mod NUM_REQ.
  - Latency: 1 cycle accept-to-strobe. Throughput: one point per cycle.
  - new_data_out is 0 on cycles without a transfer; data outputs hold their last value.
  - req_done[i] sets done_mask[i] (sticky). If a renderer's req_done and an accepted point arrive in the same cycle, the point is written.
  - done_mask all ones -> DONE, after the final strobe has issued.
- DONE: frame_done=1 for one cycle; frame_active=0 next cycle -> IDLE.
- frame_start outside IDLE: ignored.
- Once done_mask[i] is set, req_valid[i] is ignored until the next frame.
- Mid-operation reset: asynchronously aborts the frame and clears all strobes; no partial strobe is held.

Test Plan:
- Reset, then frame_start with busy=0 -> flush_out pulses the next cycle. Hold busy=1 for 5 cycles after the flush -> frame_go 1 cycle after busy falls.
- NUM_REQ=2, both valid continuously with distinct points, busy=0 -> grants alternate 0,1,0,1; new_data_out high every cycle; theta_out matches each accepted point one cycle later.
- Renderer 1 idle, renderer 0 valid -> renderer 0 granted every cycle. Assert busy mid-stream for 3 cycles -> req_ready=0 and no strobe during those cycles; stream resumes unchanged.
- Renderer 0 asserts req_done together with its last valid point (theta=1023, r=31, z=63) -> point written; no further grants to 0. Renderer 1 done 10 cycles later -> frame_done pulses once after its final strobe.
- frame_start during DRAW, and frame_start in IDLE while busy=1 -> neither produces a flush_out.
- Assert rst_in low in mid-DRAW -> all outputs 0 immediately; next frame_start runs a full frame correctly.
